// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the 1:4 TDM demultiplexer.
package tdm_demux_pkg;
  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  typedef logic [SLOT_W-1:0] slot_t;

  localparam slot_t LAST_SLOT = slot_t'(NUM_SLOTS - 1);
endpackage

// File: rtl/tdm_frame_buf.sv
// Shadow registers for slots 0..2 plus the 4-lane output frame and its valid/ready handshake.
module tdm_frame_buf
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en_i,
  input  slot_t        wr_slot_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         out_ready_i,
  output logic [W-1:0] out_a_o,
  output logic [W-1:0] out_b_o,
  output logic [W-1:0] out_c_o,
  output logic [W-1:0] out_d_o,
  output logic         out_valid_o
);

  logic [NUM_SLOTS-2:0][W-1:0] shadow_q, shadow_d;
  logic [NUM_SLOTS-1:0][W-1:0] frame_q, frame_d;
  logic                        valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      frame_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      valid_q  <= valid_d;
    end
  end

  // A completing frame overrides a same-cycle consume, so out_valid stays high with no bubble.
  always_comb begin
    shadow_d = shadow_q;
    frame_d  = frame_q;
    valid_d  = valid_q;
    if (valid_q && out_ready_i) valid_d = 1'b0;
    if (wr_en_i) begin
      if (wr_slot_i == LAST_SLOT) begin
        frame_d = {wr_data_i, shadow_q[2], shadow_q[1], shadow_q[0]};
        valid_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NUM_SLOTS - 1; i++) begin
          if (wr_slot_i == slot_t'(i)) shadow_d[i] = wr_data_i;
        end
      end
    end
  end

  assign out_a_o     = frame_q[0];
  assign out_b_o     = frame_q[1];
  assign out_c_o     = frame_q[2];
  assign out_d_o     = frame_q[3];
  assign out_valid_o = valid_q;

endmodule

// File: rtl/tdm_demux_1to4.sv
// 1:4 TDM demultiplexer: framing FSM, slot counter and error pulse.
// Optional saturating error counter on err_cnt when TDM_DEMUX_ERR_CNT_EN is defined.
module tdm_demux_1to4
  import tdm_demux_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         in_data,
  input  logic                 in_sof,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [W-1:0]         out_a,
  output logic [W-1:0]         out_b,
  output logic [W-1:0]         out_c,
  output logic [W-1:0]         out_d,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef TDM_DEMUX_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic                 frame_err
);

  state_e state_q, state_d;
  slot_t  slot_q, slot_d;
  logic   err_q, err_d;
  logic   accept;
  logic   wr_en;
  slot_t  wr_slot;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      err_q   <= err_d;
    end
  end

  // Only the slot-3 write needs the output register, so only it can stall.
  assign in_ready = !((slot_q == LAST_SLOT) && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    if (accept) begin
      unique case (state_q)
        HUNT: begin
          if (in_sof) begin
            slot_d  = slot_t'(1);
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (in_sof) begin
            slot_d = slot_t'(1);
          end else if (slot_q == '0) begin
            slot_d  = '0;
            state_d = HUNT;
          end else begin
            slot_d = slot_q + slot_t'(1);
          end
        end
        default: begin
          slot_d  = '0;
          state_d = HUNT;
        end
      endcase
    end
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_slot = slot_q;
    err_d   = 1'b0;
    if (accept) begin
      if (in_sof) begin
        wr_en   = 1'b1;
        wr_slot = '0;
        err_d   = (state_q == COLLECT) && (slot_q != '0);
      end else if (state_q == COLLECT) begin
        if (slot_q == '0) err_d = 1'b1;
        else              wr_en = 1'b1;
      end
    end
  end

  assign frame_err = err_q;

  tdm_frame_buf #(
    .W(W)
  ) u_frame_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_slot_i  (wr_slot),
    .wr_data_i  (in_data),
    .out_ready_i(out_ready),
    .out_a_o    (out_a),
    .out_b_o    (out_b),
    .out_c_o    (out_c),
    .out_d_o    (out_d),
    .out_valid_o(out_valid)
  );

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed self-checking bench for tdm_demux_1to4; err_cnt checks compile in with TDM_DEMUX_ERR_CNT_EN.
module tb_tdm_demux_1to4;
  localparam int unsigned W = 8;
  localparam int unsigned ECW = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_sof = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] out_a, out_b, out_c, out_d;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         frame_err;
`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [ECW-1:0] err_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int err_pulses = 0;
  int base;

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_err === 1'b1) err_pulses++;

  tdm_demux_1to4 #(.W(W), .ERR_CNT_W(ECW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_c    (out_c),
    .out_d    (out_d),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef TDM_DEMUX_ERR_CNT_EN
    .err_cnt  (err_cnt),
`endif
    .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n    = 1'b1;
  endtask

  task automatic send(input logic [W-1:0] d, input logic s);
    in_data  = d;
    in_sof   = s;
    in_valid = 1'b1;
    #1 chk("in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    chk({tag, ".a"}, 32'(out_a), 32'(a));
    chk({tag, ".b"}, 32'(out_b), 32'(b));
    chk({tag, ".c"}, 32'(out_c), 32'(c));
    chk({tag, ".d"}, 32'(out_d), 32'(d));
  endtask

  initial begin
    // Reset state
    step();
    do_reset();
    chk_frame("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.frame_err", 32'(frame_err), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // Basic frame with downstream ready
    base = err_pulses;
    out_ready = 1'b1;
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("t1.valid_early", 32'(out_valid), 32'd0);
    send(8'h44, 1'b0);
    chk("t1.out_valid", 32'(out_valid), 32'd1);
    chk_frame("t1", 8'h11, 8'h22, 8'h33, 8'h44);
    step();
    chk("t1.consumed", 32'(out_valid), 32'd0);
    chk_frame("t1.hold", 8'h11, 8'h22, 8'h33, 8'h44);
    chk("t1.no_err", 32'(err_pulses - base), 32'd0);

    // Leading non-sof samples dropped in HUNT
    do_reset();
    base = err_pulses;
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    send(8'hA0, 1'b1);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    chk("t2.out_valid", 32'(out_valid), 32'd1);
    chk_frame("t2", 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    step();
    chk("t2.no_err", 32'(err_pulses - base), 32'd0);

    // Backpressure and no-bubble handover
    do_reset();
    out_ready = 1'b0;
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    chk("t3.valid1", 32'(out_valid), 32'd1);
    send(8'h05, 1'b1);
    send(8'h06, 1'b0);
    send(8'h07, 1'b0);
    chk_frame("t3.held", 8'h01, 8'h02, 8'h03, 8'h04);
    in_data  = 8'h08;
    in_valid = 1'b1;
    #1 chk("t3.stall", 32'(in_ready), 32'd0);
    step();
    chk("t3.stall2", 32'(in_ready), 32'd0);
    chk_frame("t3.held2", 8'h01, 8'h02, 8'h03, 8'h04);
    out_ready = 1'b1;
    #1 chk("t3.release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("t3.no_bubble", 32'(out_valid), 32'd1);
    chk_frame("t3.new", 8'h05, 8'h06, 8'h07, 8'h08);
    step();
    chk("t3.drained", 32'(out_valid), 32'd0);

    // Early sof inside a frame is a framing error
    do_reset();
    base = err_pulses;
    send(8'h10, 1'b1);
    send(8'h20, 1'b0);
    send(8'h30, 1'b1);
    chk("t4.err_pulse", 32'(frame_err), 32'd1);
    send(8'h40, 1'b0);
    chk("t4.err_clear", 32'(frame_err), 32'd0);
    send(8'h50, 1'b0);
    send(8'h60, 1'b0);
    chk_frame("t4", 8'h30, 8'h40, 8'h50, 8'h60);
    step();
    chk("t4.err_count", 32'(err_pulses - base), 32'd1);
`ifdef TDM_DEMUX_ERR_CNT_EN
    chk("t4.err_cnt", 32'(err_cnt), 32'd1);
`endif

    // Reset mid-frame discards pending output and partial frame
    do_reset();
    out_ready = 1'b0;
    send(8'h71, 1'b1);
    send(8'h72, 1'b0);
    send(8'h73, 1'b0);
    send(8'h74, 1'b0);
    chk_frame("t5.pre", 8'h71, 8'h72, 8'h73, 8'h74);
    send(8'h81, 1'b1);
    send(8'h82, 1'b0);
    do_reset();
    chk_frame("t5.rst", 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t5.rst_valid", 32'(out_valid), 32'd0);
    base = err_pulses;
    send(8'h91, 1'b0);
    send(8'h92, 1'b0);
    chk("t5.ignored", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(8'hB0, 1'b1);
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    send(8'hB3, 1'b0);
    chk("t5.valid", 32'(out_valid), 32'd1);
    chk_frame("t5", 8'hB0, 8'hB1, 8'hB2, 8'hB3);
    step();
    chk("t5.no_err", 32'(err_pulses - base), 32'd0);

`ifdef TDM_DEMUX_ERR_CNT_EN
    // Saturating error counter, 2 bits wide
    do_reset();
    send(8'hC0, 1'b1);
    chk("t6.cnt0", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      send(8'(8'hC1 + i), 1'b1);
      chk("t6.cnt", 32'(err_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tdm_demux_1to4.md
Name: tdm_demux_1to4

Overview:
- Time-division demultiplexer: accepts a serial stream of W-bit samples on one lane (slot 0..3 per frame) and distributes each slot onto one of four parallel output lanes a/b/c/d.
- It is the counterpart of the team's 4:1 lane selector, unpacking frames that the selector path serialises.
- Sits between a serial link/FIFO (valid/ready upstream) and four-lane datapath logic (valid/ready downstream).
- Collects a full frame in shadow registers, then presents it as one 4-lane word.

Parameters:
- W, 8, sample width in bits per slot
- ERR_CNT_W, 8, width of saturating error counter (used only with optional feature)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- in_data  in  W  serial sample
- in_sof  in  1  start-of-frame; marks the sample as slot 0; qualified by in_valid
- in_valid  in  1  upstream sample valid
- in_ready  out  1  block can accept a sample this cycle
- out_a  out  W  slot 0 of last completed frame
- out_b  out  W  slot 1
- out_c  out  W  slot 2
- out_d  out  W  slot 3
- out_valid  out  1  out_a..out_d hold a complete frame
- out_ready  in  1  downstream accepts frame
- frame_err  out  1  one-cycle pulse on framing error
- err_cnt  out  ERR_CNT_W  framing error count (only with TDM_DEMUX_ERR_CNT_EN)

Behaviour:
- Transfer in: sample accepted when in_valid && in_ready. Transfer out: frame consumed when out_valid && out_ready.
- Reset (rst_n=0 at edge): state=HUNT, slot=0, shadow regs=0, out_a..out_d=0, out_valid=0, frame_err=0, err_cnt=0. in_ready is 1 in the cycle after reset. Reset mid-frame discards the partial frame and any undelivered output frame.
- FSM states:
  - HUNT: in_ready=1. Accepted samples with in_sof=0 are dropped silently, no error. Accepted sample with in_sof=1 is written to shadow slot 0; slot<=1; go to COLLECT.
  - COLLECT: accepted sample with in_sof=0 is written to shadow[slot]; slot<=slot+1.
  - Accepted sample with in_sof=1 while slot!=0 is a framing error: pulse frame_err for 1 cycle, drop the partial frame, treat the sample as a new slot 0 (slot<=1, stay in COLLECT).
  - On accepting slot 3: copy shadow 0..2 plus current in_data to out_a..out_d; out_valid<=1 next cycle; slot wraps to 0; stay in COLLECT.
  - In COLLECT with slot=0, a sample with in_sof=0 is a framing error: pulse frame_err, drop the sample, go to HUNT.
- Backpressure: in_ready=0 only when slot==3 && out_valid && !out_ready. Slots 0..2 are always accepted while the output is stalled (shadow buffering).
- Simultaneous consume and fill: if out_valid && out_ready in the same cycle as slot 3 is accepted, the new frame loads and out_valid stays 1 with no bubble.
- Plain consume: out_valid && out_ready without a new frame completing -> out_valid<=0. Outputs are held unchanged until overwritten.
- Latency: slot-3 acceptance to out_valid=1 is 1 clock. Sustained throughput is 1 frame per 4 samples.
- in_ready depends combinationally on out_ready. There is no combinational path from in_* to out_*.

Optional Feature:
- Macro: TDM_DEMUX_ERR_CNT_EN
- Defined: err_cnt port exists. It increments on each frame_err pulse and saturates at all-ones. It resets to 0.
- Undefined: err_cnt port and its counter are absent. frame_err behaviour is unchanged.

Decomposition:
- Package tdm_demux_pkg holds:
  - state enum (HUNT, COLLECT), 1-bit encoding
  - NUM_SLOTS=4 and SLOT_W=2 constants
- One natural sub-module, tdm_frame_buf: the shadow plus output registers with the out_valid/out_ready handshake.
- The top module keeps the FSM, slot counter and error logic.

Test Plan:
- Reset then send sof+0x11, 0x22, 0x33, 0x44 with out_ready=1 -> one cycle later out_a..d=0x11/0x22/0x33/0x44, out_valid=1 for one cycle; frame_err never asserted.
- Send 0x55, 0x66 (no sof) then a valid frame 0xA0..0xA3 -> leading samples dropped, no frame_err, output 0xA0/0xA1/0xA2/0xA3.
- out_ready=0, send two frames 0x01..0x04 and 0x05..0x08 -> first frame held; slots 0x05..0x07 accepted; in_ready=0 while 0x08 is presented. Raise out_ready -> 0x08 accepted that cycle, out_valid stays 1, outputs switch to 0x05..0x08 with no bubble.
- sof+0x10, 0x20, then sof+0x30, 0x40, 0x50, 0x60 -> frame_err pulses once; output 0x30/0x40/0x50/0x60. With macro defined, err_cnt=1.
- Assert rst_n=0 for 1 cycle after slot 1 of a frame -> all outputs 0 and out_valid=0 next cycle. Non-sof samples are then ignored until the next sof.
- Macro defined, ERR_CNT_W=2: force 5 framing errors -> err_cnt reads 1, 2, 3, 3, 3.
